// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with wait-state data memory handshake
//
// Optional feature macro: MEM_TIMEOUT_EN (aborts an access after TIMEOUT unacknowledged wait cycles).
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   ex_valid / ex_ready         execute-side handshake (ex_ready is combinational)
//   ex_res, ex_store_data       ALU result (address or value), store data
//   ex_mem_read, ex_mem_write   LW / SW qualifiers
//   ex_rd, ex_reg_write         destination register and its write enable
//   dmem_req/we/addr/wdata      data memory request, held until dmem_ack
//   dmem_rdata, dmem_ack        read data and one-cycle completion strobe
//   wb_valid                    one-cycle result pulse; wb_data/wb_rd/wb_reg_write/wb_fault held between pulses
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_res,
  input  logic [31:0] ex_store_data,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        wb_fault
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_d;
  logic        req_d, we_d;
  logic [31:0] addr_d, wdata_d;
  logic        wb_valid_d, wb_reg_write_d, wb_fault_d;
  logic [31:0] wb_data_d;
  logic [4:0]  wb_rd_d;
  // Destination info of the outstanding access, consumed at ack time.
  logic [4:0]  lat_rd, lat_rd_d;
  logic        lat_rw, lat_rw_d;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  logic [7:0] cnt, cnt_d;
`endif

  logic xfer;
  logic mem_op;

  assign ex_ready = (state == IDLE) && !rst;
  assign xfer     = ex_valid && ex_ready;
  assign mem_op   = ex_mem_read || ex_mem_write;

  always_comb begin
    state_d        = state;
    req_d          = dmem_req;
    we_d           = dmem_we;
    addr_d         = dmem_addr;
    wdata_d        = dmem_wdata;
    wb_valid_d     = 1'b0;
    wb_data_d      = wb_data;
    wb_rd_d        = wb_rd;
    wb_reg_write_d = wb_reg_write;
    wb_fault_d     = wb_fault;
    lat_rd_d       = lat_rd;
    lat_rw_d       = lat_rw;
`ifdef MEM_TIMEOUT_EN
    cnt_d          = cnt;
`endif
    case (state)
      IDLE: begin
        if (xfer) begin
          if (!mem_op) begin
            wb_valid_d     = 1'b1;
            wb_data_d      = ex_res;
            wb_rd_d        = ex_rd;
            wb_reg_write_d = ex_reg_write && (ex_rd != 5'd0);
            wb_fault_d     = 1'b0;
          end else if (ex_res[1:0] != 2'b00) begin
            // Misaligned: report immediately, never touch memory.
            wb_valid_d     = 1'b1;
            wb_data_d      = ex_res;
            wb_rd_d        = ex_rd;
            wb_reg_write_d = 1'b0;
            wb_fault_d     = 1'b1;
          end else begin
            req_d    = 1'b1;
            we_d     = ex_mem_write && !ex_mem_read; // read wins when both set
            addr_d   = ex_res;
            wdata_d  = ex_store_data;
            lat_rd_d = ex_rd;
            lat_rw_d = ex_reg_write;
`ifdef MEM_TIMEOUT_EN
            cnt_d    = 8'd0;
`endif
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = lat_rd;
          wb_fault_d = 1'b0;
          if (dmem_we) begin
            wb_data_d      = dmem_addr;
            wb_reg_write_d = 1'b0;
          end else begin
            wb_data_d      = dmem_rdata;
            wb_reg_write_d = lat_rw && (lat_rd != 5'd0);
          end
          state_d = IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        // Ack is tested first, so an ack on the limit cycle still succeeds.
        else if (cnt + 8'd1 == TIMEOUT_CNT) begin
          req_d          = 1'b0;
          wb_valid_d     = 1'b1;
          wb_data_d      = dmem_addr;
          wb_rd_d        = lat_rd;
          wb_reg_write_d = 1'b0;
          wb_fault_d     = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_fault     <= 1'b0;
      lat_rd       <= '0;
      lat_rw       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt          <= '0;
`endif
    end else begin
      state        <= state_d;
      dmem_req     <= req_d;
      dmem_we      <= we_d;
      dmem_addr    <= addr_d;
      dmem_wdata   <= wdata_d;
      wb_valid     <= wb_valid_d;
      wb_data      <= wb_data_d;
      wb_rd        <= wb_rd_d;
      wb_reg_write <= wb_reg_write_d;
      wb_fault     <= wb_fault_d;
      lat_rd       <= lat_rd_d;
      lat_rw       <= lat_rw_d;
`ifdef MEM_TIMEOUT_EN
      cnt          <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed table-driven bench for mem_stage
module tb_mem_stage;

`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_res;
  logic [31:0] ex_store_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_fault;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_res(ex_res),
    .ex_store_data(ex_store_data), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_fault(wb_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ex_valid      = 1'b0;
    ex_res        = '0;
    ex_store_data = '0;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
    ex_rd         = '0;
    ex_reg_write  = 1'b0;
  endtask

  // Called at a negedge with the stage idle. Ack is given in wait cycle k.
  task automatic mem_txn(input logic [31:0] addr, input logic [31:0] sdata,
                         input logic mr, input logic mw, input logic [4:0] rd,
                         input logic rw, input int k, input logic [31:0] rdata,
                         input logic exp_we);
    ex_valid = 1'b1; ex_res = addr; ex_store_data = sdata;
    ex_mem_read = mr; ex_mem_write = mw; ex_rd = rd; ex_reg_write = rw;
    chk("txn_ready_before", 32'(ex_ready), 32'd1);
    chk("txn_req_before", 32'(dmem_req), 32'd0);
    step();
    idle_inputs();
    for (int c = 1; c <= k; c++) begin
      chk("txn_req_high", 32'(dmem_req), 32'd1);
      chk("txn_ready_low", 32'(ex_ready), 32'd0);
      chk("txn_wb_quiet", 32'(wb_valid), 32'd0);
      chk("txn_we", 32'(dmem_we), 32'(exp_we));
      chk("txn_addr", dmem_addr, addr);
      if (exp_we) chk("txn_wdata", dmem_wdata, sdata);
      if (c == k) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
      end
      step();
    end
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    chk("txn_req_dropped", 32'(dmem_req), 32'd0);
    chk("txn_wb_valid", 32'(wb_valid), 32'd1);
    chk("txn_ready_back", 32'(ex_ready), 32'd1);
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] res;
    logic [31:0] sdata;
    logic        mr;
    logic        mw;
    logic        ack;
    logic [4:0]  rd;
    logic        rw;
    logic        ewv;
    logic [31:0] edata;
    logic [4:0]  erd;
    logic        erw;
    logic        ef;
  } vec_t;

  vec_t vecs [10];
  int   n;

  initial begin
    // valid res sdata mr mw ack rd rw | wv data rd rw fault
    vecs[0] = '{1'b1, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 1'b0, 5'd5,  1'b1, 1'b1, 32'h0000_1234, 5'd5,  1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'hABCD_0000, 32'h0, 1'b0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b1, 32'hABCD_0000, 5'd31, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0007, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 32'h0000_0007, 5'd0,  1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_FFFF, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3,  1'b1, 1'b0, 32'h0000_0007, 5'd0,  1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0102, 32'h0, 1'b1, 1'b0, 1'b0, 5'd4,  1'b1, 1'b1, 32'h0000_0102, 5'd4,  1'b0, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0201, 32'h1, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 32'h0000_0201, 5'd0,  1'b0, 1'b1};
    vecs[6] = '{1'b1, 32'h0000_0042, 32'h0, 1'b0, 1'b0, 1'b0, 5'd9,  1'b0, 1'b1, 32'h0000_0042, 5'd9,  1'b0, 1'b0};
    vecs[7] = '{1'b1, 32'h0000_0203, 32'h0, 1'b1, 1'b1, 1'b0, 5'd2,  1'b1, 1'b1, 32'h0000_0203, 5'd2,  1'b0, 1'b1};
    vecs[8] = '{1'b1, 32'h0000_0099, 32'h0, 1'b0, 1'b0, 1'b0, 5'd1,  1'b1, 1'b1, 32'h0000_0099, 5'd1,  1'b1, 1'b0};
    vecs[9] = '{1'b0, 32'h0000_0000, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 32'h0000_0099, 5'd1,  1'b1, 1'b0};

    rst = 1'b1;
    idle_inputs();
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ex_ready), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_rw", 32'(wb_reg_write), 32'd0);
    chk("rst_wb_fault", 32'(wb_fault), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(ex_ready), 32'd1);
    @(negedge clk);

    // Single-cycle operations, applied back to back.
    for (int i = 0; i < 10; i++) begin
      ex_valid = vecs[i].valid; ex_res = vecs[i].res; ex_store_data = vecs[i].sdata;
      ex_mem_read = vecs[i].mr; ex_mem_write = vecs[i].mw;
      ex_rd = vecs[i].rd; ex_reg_write = vecs[i].rw; dmem_ack = vecs[i].ack;
      chk($sformatf("v%0d_ready", i), 32'(ex_ready), 32'd1);
      step();
      chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'(vecs[i].ewv));
      chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].edata);
      chk($sformatf("v%0d_wb_rw", i), 32'(wb_reg_write), 32'(vecs[i].erw));
      chk($sformatf("v%0d_wb_fault", i), 32'(wb_fault), 32'(vecs[i].ef));
      chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'd0);
      if (!vecs[i].ef) chk($sformatf("v%0d_wb_rd", i), 32'(wb_rd), 32'(vecs[i].erd));
    end
    idle_inputs();
    dmem_ack = 1'b0;

    // LW with ack in the third wait cycle.
    mem_txn(32'h100, 32'h0, 1'b1, 1'b0, 5'd7, 1'b1, 3, 32'hDEADBEEF, 1'b0);
    chk("lw_data", wb_data, 32'hDEADBEEF);
    chk("lw_rd", 32'(wb_rd), 32'd7);
    chk("lw_rw", 32'(wb_reg_write), 32'd1);
    chk("lw_fault", 32'(wb_fault), 32'd0);
    step();
    chk("lw_pulse_ends", 32'(wb_valid), 32'd0);
    chk("lw_data_held", wb_data, 32'hDEADBEEF);

    // SW acked in the first cycle.
    mem_txn(32'h200, 32'hCAFEF00D, 1'b0, 1'b1, 5'd3, 1'b1, 1, 32'h1111_1111, 1'b1);
    chk("sw_data", wb_data, 32'h200);
    chk("sw_rw", 32'(wb_reg_write), 32'd0);
    chk("sw_fault", 32'(wb_fault), 32'd0);

    // LW to x0.
    mem_txn(32'h400, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1, 2, 32'h55, 1'b0);
    chk("lw_x0_data", wb_data, 32'h55);
    chk("lw_x0_rw", 32'(wb_reg_write), 32'd0);

    // Both read and write set: read wins.
    mem_txn(32'h500, 32'h77, 1'b1, 1'b1, 5'd6, 1'b1, 1, 32'h66, 1'b0);
    chk("both_data", wb_data, 32'h66);
    chk("both_rw", 32'(wb_reg_write), 32'd1);

    // New transfer in the same cycle as the previous wb pulse.
    ex_valid = 1'b1; ex_res = 32'h88; ex_rd = 5'd2; ex_reg_write = 1'b1;
    step();
    idle_inputs();
    chk("b2b_wb_valid", 32'(wb_valid), 32'd1);
    chk("b2b_wb_data", wb_data, 32'h88);

    // Reset in the second wait cycle, then a late ack.
    ex_valid = 1'b1; ex_res = 32'h300; ex_mem_read = 1'b1; ex_rd = 5'd4; ex_reg_write = 1'b1;
    step();
    idle_inputs();
    chk("rw_req_c1", 32'(dmem_req), 32'd1);
    step();
    chk("rw_req_c2", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rw_req_async_drop", 32'(dmem_req), 32'd0);
    chk("rw_ready_in_rst", 32'(ex_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hBAD0_BAD0;
    chk("rw_no_wb", 32'(wb_valid), 32'd0);
    step();
    dmem_ack = 1'b0;
    chk("rw_late_ack_no_wb", 32'(wb_valid), 32'd0);
    chk("rw_late_ack_req", 32'(dmem_req), 32'd0);
    chk("rw_late_ack_data", wb_data, 32'd0);
    chk("rw_ready_after", 32'(ex_ready), 32'd1);

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after TIMEOUT request cycles.
    ex_valid = 1'b1; ex_res = 32'h600; ex_mem_read = 1'b1; ex_rd = 5'd8; ex_reg_write = 1'b1;
    step();
    idle_inputs();
    n = 0;
    while (dmem_req && n < 20) begin
      n++;
      step();
    end
    chk("to_req_cycles", 32'(n), 32'd4);
    chk("to_wb_valid", 32'(wb_valid), 32'd1);
    chk("to_fault", 32'(wb_fault), 32'd1);
    chk("to_rw", 32'(wb_reg_write), 32'd0);
    chk("to_ready", 32'(ex_ready), 32'd1);
    // Ack on the limit cycle counts as success.
    mem_txn(32'h700, 32'h0, 1'b1, 1'b0, 5'd9, 1'b1, 4, 32'h1234_5678, 1'b0);
    chk("to_edge_data", wb_data, 32'h1234_5678);
    chk("to_edge_fault", 32'(wb_fault), 32'd0);
`else
    // Without the timeout, the access waits indefinitely for ack.
    ex_valid = 1'b1; ex_res = 32'h600; ex_mem_read = 1'b1; ex_rd = 5'd8; ex_reg_write = 1'b1;
    step();
    idle_inputs();
    n = 0;
    while (dmem_req && n < 20) begin
      n++;
      step();
    end
    chk("nt_still_waiting", 32'(n), 32'd20);
    chk("nt_no_wb", 32'(wb_valid), 32'd0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0BAD_CAFE;
    step();
    dmem_ack = 1'b0;
    chk("nt_wb_valid", 32'(wb_valid), 32'd1);
    chk("nt_data", wb_data, 32'h0BAD_CAFE);
    chk("nt_fault", 32'(wb_fault), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage placed directly downstream of the ALU. It consumes the ALU result as either a data-memory address (LW/SW) or a pass-through value, runs a request/acknowledge transaction with data memory that may take wait states, and presents one registered result per instruction to writeback. It stalls the execute stage while a memory transaction is outstanding.

## Interface
- TIMEOUT, 16: maximum wait-state cycles before an unacknowledged access is aborted (used only with MEM_TIMEOUT_EN); legal range 1..255.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- ex_valid  in  1  execute stage presents an instruction.
- ex_ready  out  1  stage can accept; a transfer occurs on a rising edge where ex_valid && ex_ready.
- ex_res  in  32  ALU result: memory address, or pass-through value.
- ex_store_data  in  32  SW write data.
- ex_mem_read  in  1  instruction is LW.
- ex_mem_write  in  1  instruction is SW.
- ex_rd  in  5  destination register index.
- ex_reg_write  in  1  instruction writes a register.
- dmem_req  out  1  memory request, held until acknowledged.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  32  word address (byte address, bits [1:0] = 0).
- dmem_wdata  out  32  write data.
- dmem_rdata  in  32  read data, valid in the cycle dmem_ack = 1.
- dmem_ack  in  1  one-cycle completion strobe.
- wb_valid  out  1  one-cycle pulse: writeback result is valid.
- wb_data  out  32  result: load data or pass-through value.
- wb_rd  out  5  destination register.
- wb_reg_write  out  1  register write enable.
- wb_fault  out  1  access faulted (misaligned, or timed out); qualified by wb_valid.

## Operation
- States: IDLE, WAIT. ex_ready = (state == IDLE) && !rst.
- IDLE, transfer, no memory op → wb_valid = 1 next cycle; wb_data = ex_res, wb_rd = ex_rd, wb_reg_write = ex_reg_write && (ex_rd != 0), wb_fault = 0; remain in IDLE.
- IDLE, transfer, memory op, ex_res[1:0] != 0 → no memory access; wb_valid next cycle with wb_fault = 1, wb_reg_write = 0, wb_data = ex_res.
- IDLE, transfer, aligned memory op → latch operands; dmem_req = 1 from the next cycle; dmem_we = ex_mem_write && !ex_mem_read (read wins if both are set); go to WAIT.
- WAIT: dmem_req, dmem_we, dmem_addr, and dmem_wdata are held stable. On dmem_ack, dmem_req drops next cycle and wb_valid pulses next cycle:
  - LW: wb_data = dmem_rdata sampled at ack; wb_reg_write = latched reg_write && rd != 0.
  - SW: wb_data = address; wb_reg_write = 0.
  - The state returns to IDLE.
- dmem_ack while in IDLE is ignored.
- Reset value of every output is 0, except ex_ready, which is 1 from the first cycle after rst deasserts. Reset asserted mid-WAIT drops dmem_req immediately (asynchronous), and no wb_valid is produced for the abandoned access. A late ack after reset is ignored.

## Timing
- All outputs except ex_ready are registered.
- Pass-through or misaligned: wb_valid 1 cycle after the transfer edge; back-to-back throughput is 1 per cycle.
- Memory op with ack in wait-state cycle k (k = 1 is the first dmem_req cycle): wb_valid at cycle k + 1 after the transfer edge. The minimum is 2 cycles.
- ex_ready is 0 from the transfer edge through the ack edge. A new instruction can transfer on the edge after the ack edge, i.e. concurrently with wb_valid.
- wb_* values are held between pulses; only wb_valid returns to 0.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - If it reaches TIMEOUT with no ack, dmem_req drops next cycle and wb_valid pulses with wb_fault = 1 and wb_reg_write = 0; the state returns to IDLE.
  - An ack in the same cycle the count reaches TIMEOUT counts as success.
- MEM_TIMEOUT_EN undefined: no counter; WAIT persists until dmem_ack. wb_fault arises only from misalignment.

## Test plan
- Pass-through: ex_res = 0x0000_1234, rd = 5, reg_write = 1, no mem op → next cycle wb_valid = 1, wb_data = 0x1234, wb_rd = 5, wb_reg_write = 1. Three back-to-back transfers → three consecutive wb pulses, with ex_ready held at 1.
- LW with 3 wait states: address 0x100, ack in the 3rd req cycle with rdata = 0xDEADBEEF → dmem_req high for exactly 3 cycles, dmem_we = 0, ex_ready = 0 throughout, wb_data = 0xDEADBEEF one cycle after ack.
- SW, ack in the first cycle: address 0x200, data 0xCAFEF00D → dmem_we = 1, dmem_wdata = 0xCAFEF00D, wb_valid 2 cycles after transfer with wb_reg_write = 0. LW to rd = 0 → wb_reg_write = 0.
- Misaligned LW to 0x102 → dmem_req stays 0; next-cycle wb_valid = 1, wb_fault = 1, wb_reg_write = 0.
- rst pulsed in the 2nd WAIT cycle, then ack one cycle later → dmem_req falls with rst, no wb_valid, ack ignored, ex_ready = 1 after release.
- With MEM_TIMEOUT_EN and TIMEOUT = 4, no ack → dmem_req high for 4 cycles, then wb_valid with wb_fault = 1 and ex_ready returns to 1.
